axi4_sram_slave: RTL and testbench

AXI4 subordinate (responder) backed by an on-chip word-addressed SRAM. It is the far end of the Core io_master bus and serves as a boot/scratchpad memory for bring-up without DDR3 or the interconnect. It has independent read and write channel FSMs, one outstanding transaction per direction, and supports FIXED/INCR/WRAP bursts with byte strobes.

---
 rtl/axi4_sram_slave.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave
//   AXI4 subordinate backed by an on-chip word-addressed SRAM of DEPTH 32-bit
//   words mapped at byte address BASE. Read and write channels have
//   independent FSMs with one outstanding burst each. FIXED, INCR and WRAP
//   bursts and byte strobes are supported.
//
// Ports
//   clock, reset_n            : single clock, asynchronous active-low reset
//   io_slave_aw*              : write address channel (awready registered)
//   io_slave_w*               : write data channel
//   io_slave_b*               : write response channel
//   io_slave_ar*              : read address channel (arready registered)
//   io_slave_r*               : read data channel, held stable until rready
module axi4_sram_slave #(
  parameter int          ID_W  = 4,
  parameter int          DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            io_slave_awready,
  input  logic            io_slave_awvalid,
  input  logic [31:0]     io_slave_awaddr,
  input  logic [ID_W-1:0] io_slave_awid,
  input  logic [7:0]      io_slave_awlen,
  input  logic [2:0]      io_slave_awsize,
  input  logic [1:0]      io_slave_awburst,
  output logic            io_slave_wready,
  input  logic            io_slave_wvalid,
  input  logic [31:0]     io_slave_wdata,
  input  logic [3:0]      io_slave_wstrb,
  input  logic            io_slave_wlast,
  input  logic            io_slave_bready,
  output logic            io_slave_bvalid,
  output logic [1:0]      io_slave_bresp,
  output logic [ID_W-1:0] io_slave_bid,
  output logic            io_slave_arready,
  input  logic            io_slave_arvalid,
  input  logic [31:0]     io_slave_araddr,
  input  logic [ID_W-1:0] io_slave_arid,
  input  logic [7:0]      io_slave_arlen,
  input  logic [2:0]      io_slave_arsize,
  input  logic [1:0]      io_slave_arburst,
  input  logic            io_slave_rready,
  output logic            io_slave_rvalid,
  output logic [1:0]      io_slave_rresp,
  output logic [31:0]     io_slave_rdata,
  output logic            io_slave_rlast,
  output logic [ID_W-1:0] io_slave_rid
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  function automatic logic in_win(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  function automatic logic wrap_ok(input logic [31:0] a, input logic [7:0] len,
                                   input logic [2:0] size);
    logic [31:0] bytes;
    bytes = 32'd1 << size;
    return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
           ((a & (bytes - 32'd1)) == 32'd0);
  endfunction

  function automatic logic burst_err(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           (burst == BURST_WRAP && !wrap_ok(a, len, size));
  endfunction

  // Reserved and illegal WRAP bursts are executed as INCR.
  function automatic logic [1:0] eff_burst(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b11 || (burst == BURST_WRAP && !wrap_ok(a, len, size)))
      return BURST_INCR;
    return burst;
  endfunction

  // WRAP keeps the high bits above the wrap boundary and lets the low bits
  // roll over, which returns to the aligned base on reaching base+boundary.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] bytes;
    logic [31:0] mask;
    bytes = 32'd1 << size;
    mask  = (bytes * (32'(len) + 32'd1)) - 32'd1;
    case (burst)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | ((a + bytes) & mask);
      default:     return a + bytes;
    endcase
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] x, input logic [1:0] y);
    return (x > y) ? x : y;
  endfunction

  logic [31:0] mem_q [DEPTH];

  // ---------------- read channel ----------------
  rstate_t         r_state_q, r_state_d;
  logic            arready_q;
  logic [31:0]     r_addr_q;
  logic [7:0]      r_len_q, r_cnt_q;
  logic [2:0]      r_size_q;
  logic [1:0]      r_burst_q;
  logic            r_err_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            rlast_q;
  logic [ID_W-1:0] rid_q;
  logic            ar_hs, r_adv;

  assign ar_hs = io_slave_arvalid && arready_q;
  assign r_adv = (r_state_q == R_DATA) && io_slave_rready && !rlast_q;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (io_slave_rready) r_state_d = rlast_q ? R_IDLE : R_FETCH;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_hs) rid_q <= io_slave_arid;
      if (r_state_q == R_FETCH) begin
        rdata_q <= in_win(r_addr_q) ? mem_q[word_idx(r_addr_q)] : 32'd0;
        rresp_q <= !in_win(r_addr_q) ? RESP_DECERR : (r_err_q ? RESP_SLVERR : RESP_OKAY);
        rlast_q <= (r_cnt_q == 8'd0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ar_hs) begin
      r_addr_q  <= io_slave_araddr;
      r_len_q   <= io_slave_arlen;
      r_cnt_q   <= io_slave_arlen;
      r_size_q  <= io_slave_arsize;
      r_burst_q <= eff_burst(io_slave_araddr, io_slave_arlen, io_slave_arsize, io_slave_arburst);
      r_err_q   <= burst_err(io_slave_araddr, io_slave_arlen, io_slave_arsize, io_slave_arburst);
    end else if (r_adv) begin
      r_addr_q <= next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
      r_cnt_q  <= r_cnt_q - 8'd1;
    end
  end

  assign io_slave_arready = arready_q;
  assign io_slave_rvalid  = (r_state_q == R_DATA);
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rlast   = rlast_q;
  assign io_slave_rid     = rid_q;

  // ---------------- write channel ----------------
  wstate_t         w_state_q, w_state_d;
  logic            awready_q;
  logic [31:0]     w_addr_q;
  logic [7:0]      w_len_q, w_cnt_q;
  logic [2:0]      w_size_q;
  logic [1:0]      w_burst_q;
  logic [1:0]      w_resp_q;
  logic [1:0]      bresp_q;
  logic [ID_W-1:0] bid_q;
  logic            aw_hs, w_beat;
  logic [1:0]      w_beat_resp;

  assign aw_hs  = io_slave_awvalid && awready_q;
  assign w_beat = (w_state_q == W_DATA) && io_slave_wvalid;
  // A wlast that does not line up with the final counted beat is a protocol
  // error; the burst still ends on wlast.
  assign w_beat_resp = !in_win(w_addr_q) ? RESP_DECERR :
                       ((io_slave_wlast != (w_cnt_q == 8'd0)) ? RESP_SLVERR : RESP_OKAY);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_beat && io_slave_wlast) w_state_d = W_RESP;
      W_RESP:  if (io_slave_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      if (aw_hs) bid_q <= io_slave_awid;
      if (w_beat && io_slave_wlast) bresp_q <= worse(w_resp_q, w_beat_resp);
    end
  end

  always_ff @(posedge clock) begin
    if (aw_hs) begin
      w_addr_q  <= io_slave_awaddr;
      w_len_q   <= io_slave_awlen;
      w_cnt_q   <= io_slave_awlen;
      w_size_q  <= io_slave_awsize;
      w_burst_q <= eff_burst(io_slave_awaddr, io_slave_awlen, io_slave_awsize, io_slave_awburst);
      w_resp_q  <= burst_err(io_slave_awaddr, io_slave_awlen, io_slave_awsize, io_slave_awburst)
                   ? RESP_SLVERR : RESP_OKAY;
    end else if (w_beat) begin
      w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
      w_cnt_q  <= w_cnt_q - 8'd1;
      w_resp_q <= worse(w_resp_q, w_beat_resp);
    end
  end

  // SRAM write port; a same-cycle read in FETCH sees the old word.
  always_ff @(posedge clock) begin
    if (w_beat && in_win(w_addr_q)) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) mem_q[word_idx(w_addr_q)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
      end
    end
  end

  assign io_slave_awready = awready_q;
  assign io_slave_wready  = (w_state_q == W_DATA);
  assign io_slave_bvalid  = (w_state_q == W_RESP);
  assign io_slave_bresp   = bresp_q;
  assign io_slave_bid     = bid_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
module tb_axi4_sram_slave;
  localparam int          ID_W  = 4;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

  logic            clock = 1'b0;
  logic            reset_n;
  logic            awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic [31:0]     awaddr, wdata;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic [3:0]      wstrb;
  logic            arready, arvalid, rready, rvalid, rlast;
  logic [31:0]     araddr, rdata;

  axi4_sram_slave #(.ID_W(ID_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst), .io_slave_wready(wready), .io_slave_wvalid(wvalid),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid), .io_slave_arready(arready), .io_slave_arvalid(arvalid),
    .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst), .io_slave_rready(rready),
    .io_slave_rvalid(rvalid), .io_slave_rresp(rresp), .io_slave_rdata(rdata),
    .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int tmo   = 0;

  logic [31:0]     mdl [DEPTH];
  logic [31:0]     wd [64];
  logic [3:0]      ws [64];
  logic [1:0]      wr_resp, exp_bresp;
  logic [ID_W-1:0] wr_bid;
  logic [31:0]     rd_data [64];
  logic [1:0]      rd_resp [64];
  logic            rd_last [64];
  logic [ID_W-1:0] rd_id;
  logic [31:0]     ex_data [64];
  logic [1:0]      ex_resp [64];
  int              rd_lat, rd_hold_bad;

  // ---------- reference model, written from the address/response rules ----------
  function automatic bit m_inwin(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic bit m_wrap_ok(input logic [31:0] a, input int size, input int len);
    return (len == 1 || len == 3 || len == 7 || len == 15) && ((a % (1 << size)) == 0);
  endfunction

  function automatic bit m_slverr(input logic [31:0] a, input int size, input int len, input int burst);
    return size > 2 || burst == 3 || (burst == 2 && !m_wrap_ok(a, size, len));
  endfunction

  function automatic int m_eff(input logic [31:0] a, input int size, input int len, input int burst);
    if (burst == 3) return 1;
    if (burst == 2 && !m_wrap_ok(a, size, len)) return 1;
    return burst;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] start, input int size, input int len,
                                         input int burst, input int beat);
    int unsigned bytes, bnd;
    logic [31:0] base;
    bytes = 1 << size;
    if (burst == 0) return start;
    if (burst == 2) begin
      bnd  = bytes * (len + 1);
      base = start - (start % bnd);
      return base + 32'(((start - base) + beat * bytes) % bnd);
    end
    return start + 32'(beat * bytes);
  endfunction

  // ---------- bus drivers (collect observations and model expectations) ----------
  task automatic do_write(input logic [31:0] addr, input logic [ID_W-1:0] id, input int len,
                          input int size, input int burst, input int nbeats);
    int n, eff;
    bit dec;
    logic [31:0] a;
    awvalid = 1; awaddr = addr; awid = id; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    n = 0; while (!awready && n < 50) begin @(negedge clock); n++; end
    if (!awready) tmo++;
    @(negedge clock); awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      n = 0; while (!wready && n < 50) begin @(negedge clock); n++; end
      if (!wready) tmo++;
      @(negedge clock);
    end
    wvalid = 0; wlast = 0; bready = 1;
    n = 0; while (!bvalid && n < 50) begin @(negedge clock); n++; end
    if (!bvalid) tmo++;
    wr_resp = bresp; wr_bid = bid;
    @(negedge clock); bready = 0;
    eff = m_eff(addr, size, len, burst);
    dec = 0;
    for (int i = 0; i < nbeats; i++) begin
      a = m_addr(addr, size, len, eff, i);
      if (m_inwin(a)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[(a - BASE) >> 2][8*b +: 8] = wd[i][8*b +: 8];
      end else dec = 1;
    end
    exp_bresp = (m_slverr(addr, size, len, burst) || nbeats != len + 1) ? 2'b10 : 2'b00;
    if (dec) exp_bresp = 2'b11;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [ID_W-1:0] id, input int len,
                         input int size, input int burst, input int hold_beat, input int hold_n);
    int n, hs, eff;
    logic [31:0] a;
    rd_hold_bad = 0; rd_lat = -1;
    arvalid = 1; araddr = addr; arid = id; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    n = 0; while (!arready && n < 50) begin @(negedge clock); n++; end
    if (!arready) tmo++;
    hs = cyc;
    @(negedge clock); arvalid = 0;
    eff = m_eff(addr, size, len, burst);
    for (int i = 0; i <= len; i++) begin
      n = 0; while (!rvalid && n < 50) begin @(negedge clock); n++; end
      if (!rvalid) tmo++;
      if (i == 0) begin rd_lat = cyc - hs; rd_id = rid; end
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
      if (i == hold_beat) begin
        for (int k = 0; k < hold_n; k++) begin
          @(negedge clock);
          if (rdata !== rd_data[i] || rvalid !== 1'b1) rd_hold_bad++;
        end
      end
      rready = 1; @(negedge clock); rready = 0;
      a = m_addr(addr, size, len, eff, i);
      ex_data[i] = m_inwin(a) ? mdl[(a - BASE) >> 2] : 32'd0;
      ex_resp[i] = !m_inwin(a) ? 2'b11 : (m_slverr(addr, size, len, burst) ? 2'b10 : 2'b00);
    end
  endtask

  // ---------- scenarios ----------
  task automatic test_reset;
    total++;
    if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid} !== '0) begin
      bad++; $display("FAIL reset_outputs: got ar=%b aw=%b rv=%b bv=%b rdata=%h want all 0",
                      arready, awready, rvalid, bvalid, rdata);
    end
    reset_n = 1; #1;
    total++;
    if (arready !== 1'b0 || awready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge: got ar=%b aw=%b want 0 0", arready, awready);
    end
    @(negedge clock);
    total++;
    if (arready !== 1'b1 || awready !== 1'b1) begin
      bad++; $display("FAIL ready_after_edge: got ar=%b aw=%b want 1 1", arready, awready);
    end
  endtask

  task automatic test_preload;
    for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(BASE, 4'd1, 63, 2, 1, 64);
    total++;
    if (wr_resp !== 2'b00) begin bad++; $display("FAIL preload0_bresp: got %b want 00", wr_resp); end
    for (int blk = 1; blk < 4; blk++) begin
      for (int i = 0; i < 64; i++) wd[i] = $urandom;
      do_write(BASE + 32'(256 * blk), 4'd1, 63, 2, 1, 64);
    end
    for (int i = 0; i < 32; i++) wd[i] = $urandom;
    do_write(TOP - 32'd128, 4'd2, 31, 2, 1, 32);
    total++;
    if (wr_resp !== 2'b00) begin bad++; $display("FAIL preload_top_bresp: got %b want 00", wr_resp); end
  endtask

  task automatic test_single;
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(BASE + 32'h10, 4'd5, 0, 2, 1, 1);
    total++;
    if (wr_resp !== 2'b00 || wr_bid !== 4'd5) begin
      bad++; $display("FAIL single_bresp: got resp=%b bid=%h want 00 5", wr_resp, wr_bid);
    end
    do_read(BASE + 32'h10, 4'd9, 0, 2, 1, -1, 0);
    total++;
    if (rd_data[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL single_rdata: got %h want deadbeef", rd_data[0]);
    end
    total++;
    if (rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00 || rd_id !== 4'd9) begin
      bad++; $display("FAIL single_rmeta: got last=%b resp=%b id=%h want 1 00 9", rd_last[0], rd_resp[0], rd_id);
    end
    total++;
    if (rd_lat !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", rd_lat); end
  endtask

  task automatic test_incr_hold;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(BASE + 32'h100, 4'd3, 3, 2, 1, 4);
    total++;
    if (wr_resp !== 2'b00) begin bad++; $display("FAIL incr_bresp: got %b want 00", wr_resp); end
    do_read(BASE + 32'h100, 4'd4, 3, 2, 1, 1, 5);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
        bad++; $display("FAIL incr_beat%0d: got data=%h last=%b want %h %b", i, rd_data[i], rd_last[i], i + 1, i == 3);
      end
    end
    total++;
    if (rd_hold_bad !== 0) begin bad++; $display("FAIL incr_hold: got %0d changes want 0", rd_hold_bad); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp [4];
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(BASE + 32'h20, 4'd0, 3, 2, 1, 4);
    exp[0] = 32'hC; exp[1] = 32'hD; exp[2] = 32'hA; exp[3] = 32'hB;
    do_read(BASE + 32'h28, 4'd6, 3, 2, 2, -1, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== exp[i] || rd_resp[i] !== 2'b00) begin
        bad++; $display("FAIL wrap_beat%0d: got data=%h resp=%b want %h 00", i, rd_data[i], rd_resp[i], exp[i]);
      end
    end
  endtask

  task automatic test_decerr;
    do_read(32'h0000_1000, 4'd2, 0, 2, 1, -1, 0);
    total++;
    if (rd_data[0] !== 32'd0 || rd_resp[0] !== 2'b11) begin
      bad++; $display("FAIL decerr_read: got data=%h resp=%b want 0 11", rd_data[0], rd_resp[0]);
    end
    wd[0] = 32'h0BAD_F00D; ws[0] = 4'hF;
    do_write(BASE, 4'd1, 0, 2, 1, 1);
    wd[0] = 32'h55AA_55AA; ws[0] = 4'hF;
    do_write(TOP, 4'd7, 0, 2, 1, 1);
    total++;
    if (wr_resp !== 2'b11 || wr_bid !== 4'd7) begin
      bad++; $display("FAIL decerr_bresp: got resp=%b bid=%h want 11 7", wr_resp, wr_bid);
    end
    do_read(BASE, 4'd1, 0, 2, 1, -1, 0);
    total++;
    if (rd_data[0] !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL decerr_nowrite: got %h want 0badf00d", rd_data[0]);
    end
  endtask

  task automatic test_early_wlast;
    logic [31:0] exp [4];
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hCAFE_0000 + 32'(i); ws[i] = 4'hF; end
    do_write(BASE + 32'h200, 4'd1, 3, 2, 1, 4);
    wd[0] = 32'h600D_0000; wd[1] = 32'h600D_0001;
    do_write(BASE + 32'h200, 4'd3, 3, 2, 1, 2);
    total++;
    if (wr_resp !== 2'b10) begin bad++; $display("FAIL early_bresp: got %b want 10", wr_resp); end
    exp[0] = 32'h600D_0000; exp[1] = 32'h600D_0001; exp[2] = 32'hCAFE_0002; exp[3] = 32'hCAFE_0003;
    do_read(BASE + 32'h200, 4'd3, 3, 2, 1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== exp[i]) begin
        bad++; $display("FAIL early_word%0d: got %h want %h", i, rd_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_strobe;
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(BASE + 32'h300, 4'd1, 0, 2, 1, 1);
    wd[0] = 32'h1234_5678; ws[0] = 4'h3;
    do_write(BASE + 32'h300, 4'd1, 0, 2, 1, 1);
    do_read(BASE + 32'h300, 4'd1, 0, 2, 1, -1, 0);
    total++;
    if (rd_data[0] !== 32'hFFFF_5678) begin
      bad++; $display("FAIL strobe: got %h want ffff5678", rd_data[0]);
    end
  endtask

  task automatic test_random;
    int size, burst, len, sel, nb;
    logic [31:0] a;
    logic [ID_W-1:0] id;
    for (int t = 0; t < 80; t++) begin
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      if (burst == 2 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else len = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h0000_1000 + 4 * $urandom_range(0, 15);
      else if (sel == 1) a = TOP - 4 * $urandom_range(1, 4);
      else               a = BASE + 4 * $urandom_range(16, 180);
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      id = ID_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 5);
        if (sel == 0)      nb = $urandom_range(1, len + 1);
        else if (sel == 1) nb = len + 2;
        else               nb = len + 1;
        for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(a, id, len, size, burst, nb);
        total++;
        if (wr_resp !== exp_bresp || wr_bid !== id) begin
          bad++; $display("FAIL rand_write%0d: got resp=%b bid=%h want %b %h", t, wr_resp, wr_bid, exp_bresp, id);
        end
      end else begin
        do_read(a, id, len, size, burst, -1, 0);
        for (int i = 0; i <= len; i++) begin
          total++;
          if (rd_data[i] !== ex_data[i] || rd_resp[i] !== ex_resp[i] || rd_last[i] !== (i == len)) begin
            bad++; $display("FAIL rand_read%0d_beat%0d: got data=%h resp=%b last=%b want %h %b %b",
                            t, i, rd_data[i], rd_resp[i], rd_last[i], ex_data[i], ex_resp[i], i == len);
          end
        end
        total++;
        if (rd_id !== id) begin bad++; $display("FAIL rand_rid%0d: got %h want %h", t, rd_id, id); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    arvalid = 1; araddr = BASE; arid = 4'd3; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    n = 0; while (!arready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock); arvalid = 0;
    n = 0; while (!rvalid && n < 50) begin @(negedge clock); n++; end
    total++;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL mid_rvalid_before: got %b want 1", rvalid); end
    #2 reset_n = 0;
    #1;
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_drop: got rvalid=%b arready=%b want 0 0", rvalid, arready);
    end
    @(negedge clock); reset_n = 1;
    @(negedge clock);
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL mid_arready_release: got %b want 1", arready); end
    do_read(BASE + 32'h40, 4'd8, 3, 2, 1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== ex_data[i] || rd_resp[i] !== 2'b00) begin
        bad++; $display("FAIL mid_read_beat%0d: got %h resp=%b want %h 00", i, rd_data[i], rd_resp[i], ex_data[i]);
      end
    end
  endtask

  task automatic check_timeouts;
    total++;
    if (tmo !== 0) begin bad++; $display("FAIL handshake_timeout: got %0d expired waits want 0", tmo); end
  endtask

  initial begin
    reset_n = 0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge clock);
    test_reset();
    test_preload();
    test_single();
    test_incr_hold();
    test_wrap();
    test_decerr();
    test_early_wlast();
    test_strobe();
    test_random();
    test_reset_mid();
    check_timeouts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
